gpio_port: RTL

Parametrised general-purpose I/O port on the system register bus, successor to the fixed two-register direction/data pair at 0x2060/0x2061. Provides up to 8 pins with per-pin direction, output data, 2-flop input synchronisation, counter-based debounce and edge-selectable interrupt flags. It sits beside the other register-mapped peripherals; its `bus_data_out` is ORed into the shared register read bus. Its `irq` output feeds a slot of the interrupt controller's `irqs` vector.

---
 rtl/gpio_port_if.sv | 22 ++
 rtl/gpio_port.sv | 126 ++++++++++++
 2 files changed

// File: rtl/gpio_port_if.sv
// Register-bus connection shared by gpio_port and whoever drives it.
// The master issues single-cycle writes and reads bus_data_out combinationally.
interface gpio_port_if;
    logic        bus_write;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;

    modport master (
        output bus_write,
        output bus_address_in,
        output bus_data_in,
        input  bus_data_out
    );

    modport slave (
        input  bus_write,
        input  bus_address_in,
        input  bus_data_in,
        output bus_data_out
    );
endinterface

// File: rtl/gpio_port.sv
// Register-mapped GPIO port: per-pin direction and output latch, synchronised and
// debounced inputs, and edge-selectable interrupt flags cleared by write-1.
module gpio_port #(
    parameter logic [23:0] BASE_ADDR       = 24'h2060,
    parameter int          NUM_PINS        = 8,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    gpio_port_if.slave          bus,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic [NUM_PINS-1:0] pin_out,
    output logic [NUM_PINS-1:0] pin_oe,
    output logic                irq
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0]      ADDR_DIR  = BASE_ADDR;
    localparam logic [23:0]      ADDR_DATA = BASE_ADDR + 24'd1;
    localparam logic [23:0]      ADDR_EN   = BASE_ADDR + 24'd2;
    localparam logic [23:0]      ADDR_EDGE = BASE_ADDR + 24'd3;
    localparam logic [23:0]      ADDR_FLAG = BASE_ADDR + 24'd4;

    logic [NUM_PINS-1:0] dir_r;
    logic [NUM_PINS-1:0] data_r;
    logic [NUM_PINS-1:0] en_r;
    logic [NUM_PINS-1:0] edge_r;
    logic [NUM_PINS-1:0] flag_r;
    logic [NUM_PINS-1:0] s1;
    logic [NUM_PINS-1:0] s2;
    logic [NUM_PINS-1:0] deb;
    logic [CNT_W-1:0]    cnt [NUM_PINS];

    logic [NUM_PINS-1:0] upd;
    logic [NUM_PINS-1:0] flag_set;
    logic [NUM_PINS-1:0] flag_clr;
    logic                wr_dir;
    logic                wr_data;
    logic                wr_en;
    logic                wr_edge;
    logic                wr_flag;
    logic [7:0]          rdata;

    // Bus lanes above NUM_PINS are dropped on write and read back as zero.
    function automatic logic [NUM_PINS-1:0] from_bus(input logic [7:0] d);
        return d[NUM_PINS-1:0];
    endfunction

    function automatic logic [7:0] to_bus(input logic [NUM_PINS-1:0] v);
        logic [7:0] r;
        r = 8'h00;
        r[NUM_PINS-1:0] = v;
        return r;
    endfunction

    assign wr_dir  = bus.bus_write && (bus.bus_address_in == ADDR_DIR);
    assign wr_data = bus.bus_write && (bus.bus_address_in == ADDR_DATA);
    assign wr_en   = bus.bus_write && (bus.bus_address_in == ADDR_EN);
    assign wr_edge = bus.bus_write && (bus.bus_address_in == ADDR_EDGE);
    assign wr_flag = bus.bus_write && (bus.bus_address_in == ADDR_FLAG);

    // A pin's debounced value flips when s2 has differed for the full count.
    always_comb begin
        upd = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            upd[i] = (s2[i] != deb[i]) && (cnt[i] == CNT_LAST);
        end
    end

    assign flag_set = (upd & s2 & edge_r) | (upd & ~s2 & ~edge_r);
    assign flag_clr = wr_flag ? from_bus(bus.bus_data_in) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            dir_r  <= '0;
            data_r <= '0;
            en_r   <= '0;
            edge_r <= '0;
            flag_r <= '0;
            s1     <= '0;
            s2     <= '0;
            deb    <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // synchroniser
            s1 <= pin_in;
            s2 <= s1;
            // debounce
            for (int i = 0; i < NUM_PINS; i++) begin
                if (s2[i] == deb[i] || upd[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            deb <= deb ^ upd;
            // registers; a new edge outranks a same-cycle clear
            if (wr_dir)  dir_r  <= from_bus(bus.bus_data_in);
            if (wr_data) data_r <= from_bus(bus.bus_data_in);
            if (wr_en)   en_r   <= from_bus(bus.bus_data_in);
            if (wr_edge) edge_r <= from_bus(bus.bus_data_in);
            flag_r <= (flag_r & ~flag_clr) | flag_set;
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (bus.bus_address_in)
            ADDR_DIR:  rdata = to_bus(dir_r);
            ADDR_DATA: rdata = to_bus((dir_r & data_r) | (~dir_r & deb));
            ADDR_EN:   rdata = to_bus(en_r);
            ADDR_EDGE: rdata = to_bus(edge_r);
            ADDR_FLAG: rdata = to_bus(flag_r);
            default:   rdata = 8'h00;
        endcase
    end

    assign bus.bus_data_out = rdata;
    assign pin_out          = data_r;
    assign pin_oe           = dir_r;
    assign irq              = |(flag_r & en_r);

endmodule
